// File: rtl/pdm_rdctrl.sv
// Read-back controller for the PDM capture buffer: walks indices 0..BOUND and
// streams the words through a first-word-fall-through FIFO sized to the read latency.
module pdm_rdctrl #(
  parameter int BOUND  = 46874,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_bsy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              bsy,
  output logic              done
);
  localparam int DEPTH = 2 * RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BOUND);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [RD_LAT-1:0] vld_p, last_p;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  last_mem;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count, inflight, occ;
  logic              flush, wr, rd, issue_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LAT; k++) inflight = inflight + CNT_W'(vld_p[k]);
  end

  // Occupancy counts reads still in flight so the FIFO can never overflow.
  assign occ        = count + inflight;
  assign rd_en      = (state == READ) && (occ < CNT_W'(DEPTH));
  assign issue_last = rd_en && (raddr == LAST_ADDR);
  assign flush      = rst || (state == DONE) || (abort && (state == READ || state == DRAIN));
  assign wr         = vld_p[RD_LAT-1] && !flush;
  assign m_valid    = (count != '0);
  assign rd         = m_valid && m_ready;
  assign m_data     = m_valid ? mem[rptr] : '0;
  assign m_last     = m_valid && last_mem[rptr];
  assign bsy        = (state == READ) || (state == DRAIN);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !wr_bsy && !abort) state_nxt = READ;
      READ:    if (abort) state_nxt = IDLE;
               else if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (rd && m_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0..pN: in-flight read tracking, one slot per cycle of memory latency.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_p  <= '0;
      last_p <= '0;
      count  <= '0;
      wptr   <= '0;
      rptr   <= '0;
      raddr  <= '0;
    end else begin
      vld_p[0]  <= rd_en;
      last_p[0] <= issue_last;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_p[k]  <= vld_p[k-1];
        last_p[k] <= last_p[k-1];
      end
      if (wr) wptr <= ptr_inc(wptr);
      if (rd) rptr <= ptr_inc(rptr);
      count <= count + CNT_W'(wr) - CNT_W'(rd);
      if (rd_en && !issue_last) raddr <= raddr + 1'b1;
    end
  end

  // FIFO storage: data only, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr]      <= rdata;
      last_mem[wptr] <= last_p[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_pdm_rdctrl.sv
// Directed bench for pdm_rdctrl: four instances with different latency/bound,
// each fed by a fixed-latency memory model holding mem[i] = 3*i + 1.
module tb_pdm_rdctrl;
  localparam int LATS [4] = '{1, 3, 2, 1};
  localparam int BNDS [4] = '{7, 15, 0, 31};

  logic        clk;
  logic        rst;
  logic        start   [4];
  logic        abort   [4];
  logic        wr_bsy  [4];
  logic        m_ready [4];
  logic        rd_en   [4];
  logic        m_valid [4];
  logic        m_last  [4];
  logic        bsy     [4];
  logic        done    [4];
  logic [15:0] raddr   [4];
  logic [31:0] rdata   [4];
  logic [31:0] m_data  [4];

  int n_chk  = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int L = LATS[g];
    logic [15:0] a_d [L];
    logic        e_d [L];

    pdm_rdctrl #(.BOUND(BNDS[g]), .ADDR_W(16), .DATA_W(32), .RD_LAT(L)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]), .wr_bsy(wr_bsy[g]),
      .rd_en(rd_en[g]), .raddr(raddr[g]), .rdata(rdata[g]), .m_data(m_data[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_last(m_last[g]),
      .bsy(bsy[g]), .done(done[g])
    );

    always @(posedge clk) begin
      a_d[0] <= raddr[g];
      e_d[0] <= rd_en[g];
      for (int k = 1; k < L; k++) begin
        a_d[k] <= a_d[k-1];
        e_d[k] <= e_d[k-1];
      end
    end
    assign rdata[g] = e_d[L-1] ? 32'(3 * a_d[L-1] + 1) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_chk(input int idx, input string tag);
    chk({tag, "_rd_en"},   32'(rd_en[idx]),   32'd0);
    chk({tag, "_raddr"},   32'(raddr[idx]),   32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid[idx]), 32'd0);
    chk({tag, "_m_last"},  32'(m_last[idx]),  32'd0);
    chk({tag, "_m_data"},  m_data[idx],       32'd0);
    chk({tag, "_bsy"},     32'(bsy[idx]),     32'd0);
    chk({tag, "_done"},    32'(done[idx]),    32'd0);
  endtask

  // Runs one read-back to completion; ends in the IDLE cycle after done.
  task automatic run_stream(input int idx, input int bound, input int depth, input int hold,
                            input bit rnd, input bit do_start, input int spur);
    int          issued = 0;
    int          xfer   = 0;
    int          maxo   = 0;
    bit          fin    = 1'b0;
    bit          due    = 1'b0;
    bit          stall  = 1'b0;
    logic [31:0] pd     = '0;
    logic        pl     = 1'b0;
    if (do_start) begin
      start[idx] = 1'b1;
      tick();
      start[idx] = 1'b0;
    end
    for (int c = 1; c < 600 && !fin; c++) begin
      m_ready[idx] = (c <= hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      start[idx]   = (c == spur);
      if (issued - xfer > maxo) maxo = issued - xfer;
      if (stall) begin
        chk("hold_data", m_data[idx], pd);
        chk("hold_last", 32'(m_last[idx]), 32'(pl));
      end
      if (due) begin
        chk("done", 32'(done[idx]), 32'd1);
        chk("bsy_in_done", 32'(bsy[idx]), 32'd0);
        fin = 1'b1;
      end else begin
        chk("no_done", 32'(done[idx]), 32'd0);
        if (rd_en[idx]) begin
          chk("raddr", 32'(raddr[idx]), 32'(issued));
          issued++;
        end
        if (m_valid[idx] && m_ready[idx]) begin
          chk("word", m_data[idx], 32'(3 * xfer + 1));
          chk("last", 32'(m_last[idx]), 32'(xfer == bound));
          if (m_last[idx]) due = 1'b1;
          xfer++;
        end
      end
      stall = m_valid[idx] && !m_ready[idx];
      pd    = m_data[idx];
      pl    = m_last[idx];
      tick();
    end
    start[idx]   = 1'b0;
    m_ready[idx] = 1'b1;
    chk("finished", 32'(fin), 32'd1);
    chk("words", 32'(xfer), 32'(bound + 1));
    chk("reads", 32'(issued), 32'(bound + 1));
    if (depth > 0) chk("max_occ", 32'(maxo), 32'(depth));
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 4; i++) begin
      start[i]   = 1'b0;
      abort[i]   = 1'b0;
      wr_bsy[i]  = 1'b0;
      m_ready[i] = 1'b1;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) idle_chk(i, "reset");
    rst = 1'b0;
    tick();

    // Basic: RD_LAT=1, BOUND=7, exact cycle table.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk("b_rd_en", 32'(rd_en[0]), 32'(k <= 8));
      if (k <= 8) chk("b_raddr", 32'(raddr[0]), 32'(k - 1));
      chk("b_valid", 32'(m_valid[0]), 32'(k >= 3 && k <= 10));
      chk("b_data", m_data[0], (k >= 3 && k <= 10) ? 32'(3 * (k - 3) + 1) : 32'd0);
      chk("b_last", 32'(m_last[0]), 32'(k == 10));
      chk("b_done", 32'(done[0]), 32'(k == 11));
      chk("b_bsy", 32'(bsy[0]), 32'(k <= 10));
      tick();
    end

    // Blocked start, then release wr_bsy with start still high.
    wr_bsy[0] = 1'b1;
    start[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("blk_rd_en", 32'(rd_en[0]), 32'd0);
      chk("blk_bsy", 32'(bsy[0]), 32'd0);
    end
    wr_bsy[0] = 1'b0;
    tick();
    start[0]  = 1'b0;
    wr_bsy[0] = 1'b1;
    chk("rel_bsy", 32'(bsy[0]), 32'd1);
    chk("rel_rd_en", 32'(rd_en[0]), 32'd1);
    run_stream(0, 7, -1, 0, 1'b0, 1'b0, -1);
    wr_bsy[0] = 1'b0;

    // Backpressure: RD_LAT=3, BOUND=15, ready held low then random.
    run_stream(1, 15, 8, 10, 1'b1, 1'b1, -1);

    // BOUND=0: one word carrying m_last.
    run_stream(2, 0, -1, 0, 1'b0, 1'b1, -1);

    // Abort: BOUND=31, m_ready=0, abort in cycle 6.
    m_ready[3] = 1'b0;
    start[3]   = 1'b1;
    tick();
    start[3] = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    chk("ab_pre_valid", 32'(m_valid[3]), 32'd1);
    chk("ab_pre_bsy", 32'(bsy[3]), 32'd1);
    abort[3] = 1'b1;
    tick();
    abort[3] = 1'b0;
    idle_chk(3, "abort");
    tick();
    idle_chk(3, "abort2");
    tick();
    run_stream(3, 31, -1, 0, 1'b0, 1'b1, -1);

    // Reset mid-stream at word 5 of instance 0.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_valid[0] && m_data[0] == 32'd16) begin
        found = 1'b1;
        rst   = 1'b1;
      end
      tick();
    end
    chk("word5_seen", 32'(found), 32'd1);
    rst = 1'b0;
    idle_chk(0, "rst_mid");
    tick();

    // Start while busy is ignored; block returns to IDLE after one run.
    run_stream(0, 7, -1, 0, 1'b0, 1'b1, 3);
    for (int k = 0; k < 3; k++) begin
      idle_chk(0, "post_run");
      tick();
    end

    // start together with abort in IDLE: abort wins.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    idle_chk(0, "st_ab");
    tick();
    idle_chk(0, "st_ab2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
